result_bus_arbiter: RTL and testbench

RESULT_BUS_ARBITER -- requirements
Module: result_bus_arbiter

---
 rtl/result_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_result_bus_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_bus_arbiter.sv
// result_bus_arbiter: grants up to BUS_COUNT ready result stations per cycle
// onto broadcast buses. Grants are registered, so a station granted at edge N
// appears on its bus, with its station_done pulse, for the cycle after edge N.
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous, active-high reset
//   station_ready  per station: holds a valid result
//   station_result per station: result value, valid while station_ready
//   station_done   per station: one-cycle pulse, result is on a bus this cycle
//   bus_asserted   per bus: carries a valid broadcast this cycle
//   bus_source     per bus: index of the broadcasting station
//   bus_value      per bus: broadcast result
//
// Build option: define RESULT_BUS_ROUND_ROBIN_EN for a rotating priority
// pointer. Without it, the search always starts at station 0.
module result_bus_arbiter #(
  parameter int unsigned SIZE               = 32,
  parameter int unsigned STATION_INDEX_SIZE = 2,
  parameter int unsigned STATION_COUNT      = 4,
  parameter int unsigned BUS_COUNT          = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [0:STATION_COUNT-1]      station_ready,
  input  logic [SIZE-1:0]               station_result [0:STATION_COUNT-1],
  output logic [0:STATION_COUNT-1]      station_done,
  output logic [0:BUS_COUNT-1]          bus_asserted,
  output logic [STATION_INDEX_SIZE-1:0] bus_source [0:BUS_COUNT-1],
  output logic [SIZE-1:0]               bus_value [0:BUS_COUNT-1]
);

  localparam int NST  = int'(STATION_COUNT);
  localparam int NBUS = int'(BUS_COUNT);

  logic [STATION_INDEX_SIZE-1:0] ptr;
  logic [0:STATION_COUNT-1]      eligible;
  logic [0:STATION_COUNT-1]      grant;
  int                            offset [0:STATION_COUNT-1];
  int                            rank   [0:STATION_COUNT-1];

  logic [0:BUS_COUNT-1]          nxt_asserted;
  logic [STATION_INDEX_SIZE-1:0] nxt_source [0:BUS_COUNT-1];
  logic [SIZE-1:0]               nxt_value  [0:BUS_COUNT-1];

  // A station currently on a bus is already freeing itself; never regrant it.
  assign eligible = station_ready & ~station_done;

  // Search distance of each station from the pointer, and its rank among
  // eligible stations in that search order; the first BUS_COUNT ranks win.
  always_comb begin : rank_logic
    grant = '0;
    for (int j = 0; j < NST; j++) begin
      offset[j] = (j >= int'(ptr)) ? (j - int'(ptr)) : (j + NST - int'(ptr));
    end
    for (int j = 0; j < NST; j++) begin
      rank[j] = 0;
      for (int m = 0; m < NST; m++) begin
        if (eligible[m] && (offset[m] < offset[j])) rank[j] = rank[j] + 1;
      end
      grant[j] = eligible[j] && (rank[j] < NBUS);
    end
  end

  // The k-th granted station in search order loads bus k.
  always_comb begin : bus_load
    nxt_asserted = '0;
    for (int b = 0; b < NBUS; b++) begin
      nxt_source[b] = '0;
      nxt_value[b]  = '0;
    end
    for (int b = 0; b < NBUS; b++) begin
      for (int j = 0; j < NST; j++) begin
        if (grant[j] && (rank[j] == b)) begin
          nxt_asserted[b] = 1'b1;
          nxt_source[b]   = STATION_INDEX_SIZE'(j);
          nxt_value[b]    = station_result[j];
        end
      end
    end
  end

  // Output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      station_done <= '0;
      bus_asserted <= '0;
      for (int b = 0; b < NBUS; b++) begin
        bus_source[b] <= '0;
        bus_value[b]  <= '0;
      end
    end else begin
      station_done <= grant;
      bus_asserted <= nxt_asserted;
      for (int b = 0; b < NBUS; b++) begin
        bus_source[b] <= nxt_source[b];
        bus_value[b]  <= nxt_value[b];
      end
    end
  end

`ifdef RESULT_BUS_ROUND_ROBIN_EN
  logic                          any_grant;
  int                            last_offset;
  int                            last_station;
  logic [STATION_INDEX_SIZE-1:0] nxt_ptr;

  // Pointer moves just past the last station granted in search order.
  always_comb begin : ptr_next
    any_grant    = |grant;
    last_offset  = -1;
    last_station = 0;
    for (int j = 0; j < NST; j++) begin
      if (grant[j] && (offset[j] > last_offset)) begin
        last_offset  = offset[j];
        last_station = j;
      end
    end
    nxt_ptr = ((last_station + 1) >= NST) ? '0
                                          : STATION_INDEX_SIZE'(last_station + 1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (any_grant) begin
      ptr <= nxt_ptr;
    end
  end
`else
  // Fixed priority: station 0 always searched first.
  assign ptr = '0;
`endif

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Randomized and directed bench for result_bus_arbiter. Two instances run side
// by side: one with a single bus, one with two buses. A queue-based reference
// model derives each cycle's grants from the arbitration rules.
module tb_result_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [0:3]  rdy1, rdy2;
  logic [31:0] res1 [0:3];
  logic [31:0] res2 [0:3];

  logic [0:3]  done1, done2;
  logic [0:0]  bas1;
  logic [1:0]  src1 [0:0];
  logic [31:0] val1 [0:0];
  logic [0:1]  bas2;
  logic [1:0]  src2 [0:1];
  logic [31:0] val2 [0:1];

  logic [38:0] obs1, exp1;
  logic [73:0] obs2, exp2;

  int          vectors = 0;
  int          miscompares = 0;

  // Reference model state per instance: priority pointer and done bits.
  int          mp [0:1];
  logic [0:3]  md [0:1];

  always #5 clock = ~clock;

  result_bus_arbiter #(.SIZE(32), .STATION_INDEX_SIZE(2), .STATION_COUNT(4), .BUS_COUNT(1)) u_dut1 (
    .clock(clock), .reset(reset), .station_ready(rdy1), .station_result(res1),
    .station_done(done1), .bus_asserted(bas1), .bus_source(src1), .bus_value(val1));

  result_bus_arbiter #(.SIZE(32), .STATION_INDEX_SIZE(2), .STATION_COUNT(4), .BUS_COUNT(2)) u_dut2 (
    .clock(clock), .reset(reset), .station_ready(rdy2), .station_result(res2),
    .station_done(done2), .bus_asserted(bas2), .bus_source(src2), .bus_value(val2));

  assign obs1 = {done1, bas1, src1[0], val1[0]};
  assign obs2 = {done2, bas2, src2[0], src2[1], val2[0], val2[1]};

  task automatic model_reset();
    mp[0] = 0; mp[1] = 0;
    md[0] = '0; md[1] = '0;
    exp1  = '0; exp2 = '0;
  endtask

  // One clock edge of the reference: collect eligible stations in search
  // order, hand the first nb of them to buses 0..nb-1.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int          nb;
      int          q[$];
      int          st;
      int          used;
      logic [0:3]  r;
      logic [0:3]  nd;
      logic [0:1]  as;
      logic [1:0]  s [0:1];
      logic [31:0] v [0:1];
      q.delete();
      nb = d + 1;
      r  = (d == 0) ? rdy1 : rdy2;
      for (int k = 0; k < 4; k++) begin
        st = (mp[d] + k) % 4;
        if (r[st] && !md[d][st]) q.push_back(st);
      end
      nd = '0; as = '0;
      for (int b = 0; b < 2; b++) begin s[b] = '0; v[b] = '0; end
      used = (q.size() < nb) ? q.size() : nb;
      for (int b = 0; b < used; b++) begin
        as[b]    = 1'b1;
        s[b]     = 2'(q[b]);
        v[b]     = (d == 0) ? res1[q[b]] : res2[q[b]];
        nd[q[b]] = 1'b1;
      end
`ifdef RESULT_BUS_ROUND_ROBIN_EN
      if (used > 0) mp[d] = (q[used-1] + 1) % 4;
`endif
      md[d] = nd;
      if (d == 0) exp1 = {nd, as[0], s[0], v[0]};
      else        exp2 = {nd, as[0], as[1], s[0], s[1], v[0], v[1]};
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    rdy1 = '0; rdy2 = '0;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    rdy1 = '0; rdy2 = '0;
    for (int k = 0; k < 4; k++) begin res1[k] = '0; res2[k] = '0; end
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (obs1 !== 39'd0) begin miscompares++; $display("FAIL reset_async_1: got %h expected %h", obs1, 39'd0); end
    vectors++;
    if (obs2 !== 74'd0) begin miscompares++; $display("FAIL reset_async_2: got %h expected %h", obs2, 74'd0); end
    rdy1 = '1; rdy2 = '1;
    @(posedge clock); #1;
    vectors++;
    if (obs1 !== 39'd0) begin miscompares++; $display("FAIL reset_held_1: got %h expected %h", obs1, 39'd0); end
    vectors++;
    if (obs2 !== 74'd0) begin miscompares++; $display("FAIL reset_held_2: got %h expected %h", obs2, 74'd0); end
    @(negedge clock);
    rdy1 = '0; rdy2 = '0;
    reset = 1'b0;
  endtask

  task automatic test_single_ready();
    do_reset();
    res1[2] = 32'h0000_00AB;
    rdy1 = 4'b0010;
    tick();
    vectors++;
    if (obs1 !== {4'b0010, 1'b1, 2'd2, 32'h0000_00AB}) begin
      miscompares++; $display("FAIL single_grant: got %h expected %h", obs1, {4'b0010, 1'b1, 2'd2, 32'h0000_00AB});
    end
    vectors++;
    if (obs1 !== exp1) begin miscompares++; $display("FAIL single_grant_model: got %h expected %h", obs1, exp1); end
    tick();
    vectors++;
    if (obs1 !== 39'd0) begin miscompares++; $display("FAIL single_no_regrant: got %h expected %h", obs1, 39'd0); end
    rdy1 = '0;
  endtask

  task automatic test_contention();
    logic [0:3] prev;
    do_reset();
    for (int k = 0; k < 4; k++) res1[k] = $urandom();
    rdy1 = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      prev = md[0];
      tick();
      vectors++;
      if (obs1 !== exp1) begin miscompares++; $display("FAIL contention_model c=%0d: got %h expected %h", c, obs1, exp1); end
      vectors++;
      if (bas1[0] !== 1'b1 || src1[0] !== 2'(c)) begin
        miscompares++; $display("FAIL contention_order c=%0d: got asserted=%b source=%0d expected asserted=1 source=%0d", c, bas1[0], src1[0], c);
      end
      rdy1 = rdy1 & ~prev;
    end
    rdy1 = '0;
  endtask

  task automatic test_multibus();
    do_reset();
    for (int k = 0; k < 4; k++) res2[k] = $urandom();
    rdy2 = 4'b0101;
    tick();
    vectors++;
    if (obs2 !== {4'b0101, 2'b11, 2'd1, 2'd3, res2[1], res2[3]}) begin
      miscompares++; $display("FAIL multibus_pair: got %h expected %h", obs2, {4'b0101, 2'b11, 2'd1, 2'd3, res2[1], res2[3]});
    end
    vectors++;
    if (obs2 !== exp2) begin miscompares++; $display("FAIL multibus_pair_model: got %h expected %h", obs2, exp2); end
    rdy2 = '0;
    tick();
    vectors++;
    if (obs2 !== 74'd0) begin miscompares++; $display("FAIL multibus_idle: got %h expected %h", obs2, 74'd0); end
    rdy2 = '1;
    tick();
    vectors++;
    if (src2[0] !== 2'd0 || src2[1] !== 2'd1 || bas2 !== 2'b11) begin
      miscompares++; $display("FAIL multibus_ptr0: got sources %0d,%0d asserted %b expected 0,1 asserted 11", src2[0], src2[1], bas2);
    end
    tick();
    vectors++;
    if (obs2 !== exp2) begin miscompares++; $display("FAIL multibus_rest_model: got %h expected %h", obs2, exp2); end
    rdy2 = '0;
  endtask

  task automatic test_fixed_priority();
    do_reset();
    for (int k = 0; k < 4; k++) res1[k] = $urandom();
    for (int c = 0; c < 10; c++) begin
      rdy1 = {(c % 2 == 0), 1'b0, 1'b0, 1'b1};
      tick();
      vectors++;
      if (obs1 !== exp1) begin miscompares++; $display("FAIL priority_model c=%0d: got %h expected %h", c, obs1, exp1); end
      vectors++;
      if (src1[0] !== ((c % 2 == 0) ? 2'd0 : 2'd3)) begin
        miscompares++; $display("FAIL priority_source c=%0d: got %0d expected %0d", c, src1[0], (c % 2 == 0) ? 0 : 3);
      end
    end
    rdy1 = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 4; k++) res1[k] = $urandom();
    rdy1 = 4'b0100;
    tick();
    vectors++;
    if (obs1 !== {4'b0100, 1'b1, 2'd1, res1[1]}) begin
      miscompares++; $display("FAIL areset_pre: got %h expected %h", obs1, {4'b0100, 1'b1, 2'd1, res1[1]});
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (obs1 !== 39'd0) begin miscompares++; $display("FAIL areset_clear: got %h expected %h", obs1, 39'd0); end
    @(negedge clock);
    reset = 1'b0;
    tick();
    vectors++;
    if (obs1 !== {4'b0100, 1'b1, 2'd1, res1[1]}) begin
      miscompares++; $display("FAIL areset_first_grant: got %h expected %h", obs1, {4'b0100, 1'b1, 2'd1, res1[1]});
    end
    rdy1 = '0;
  endtask

  task automatic test_idle();
    do_reset();
    for (int k = 0; k < 4; k++) res1[k] = $urandom();
    rdy1 = 4'b0100;
    tick();
    vectors++;
    if (obs1 !== exp1) begin miscompares++; $display("FAIL idle_setup: got %h expected %h", obs1, exp1); end
    rdy1 = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if (obs1 !== 39'd0) begin miscompares++; $display("FAIL idle c=%0d: got %h expected %h", c, obs1, 39'd0); end
    end
    rdy1 = '1;
    tick();
    vectors++;
    if (obs1 !== exp1) begin miscompares++; $display("FAIL idle_ptr_held: got %h expected %h", obs1, exp1); end
    rdy1 = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rdy1 = 4'($urandom());
      rdy2 = 4'($urandom());
      for (int k = 0; k < 4; k++) begin res1[k] = $urandom(); res2[k] = $urandom(); end
      tick();
      vectors++;
      if (obs1 !== exp1) begin miscompares++; $display("FAIL random_1 c=%0d: got %h expected %h", c, obs1, exp1); end
      vectors++;
      if (obs2 !== exp2) begin miscompares++; $display("FAIL random_2 c=%0d: got %h expected %h", c, obs2, exp2); end
      if ($urandom_range(0, 63) == 0) begin
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (obs2 !== 74'd0) begin miscompares++; $display("FAIL random_reset c=%0d: got %h expected %h", c, obs2, 74'd0); end
        @(negedge clock);
        reset = 1'b0;
      end
    end
    rdy1 = '0; rdy2 = '0;
  endtask

  initial begin
    test_reset();
    test_single_ready();
    test_contention();
    test_multibus();
    test_fixed_priority();
    test_async_reset();
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule
